conv5x5_pe: RTL and testbench
=============================

# conv5x5_pe

Quantized 5x5 convolution processing element for the first conv layer. Consumes the 25-pixel window bus and window-valid strobe produced by the upstream 5x5 line/window buffer. Multiplies each window by a run-time-loaded signed 8-bit kernel, adds a signed 16-bit bias, and requantizes to an unsigned 8-bit ReLU activation. Tracks output position across the 24x24 feature map and raises a one-cycle done interrupt after the final output.

## Interface
- OUT_W, 24, output feature-map width (windows per row)
- OUT_H, 24, output feature-map height (rows)
- SHIFT, 4, requantization arithmetic right-shift amount (0..15)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; asynchronous, active-high
- in_data1..in_data25  in  8 each  unsigned window pixels, row-major (1..5 = top row, 21..25 = bottom row)
- in_valid  in  1  window valid, one window per asserted cycle
- w_load_valid  in  1  kernel/bias load strobe
- w_load_data  in  16  load word; weights use [7:0] as signed int8, bias uses all 16 bits as signed
- w_ready  out  1  high when all 25 weights and the bias are loaded (state READY)
- out_data  out  8  unsigned activation
- out_valid  out  1  out_data valid, single-cycle per result
- out_last  out  1  qualifies out_valid for the final (row OUT_H-1, col OUT_W-1) result
- conv_done_intr  out  1  one-cycle pulse, the cycle after out_last

## Operation
- Load FSM states: EMPTY, LOAD, READY. Reset → EMPTY.
- EMPTY: w_load_valid → LOAD; the first word is captured as weight 1 and the load counter is set to 1.
- LOAD: each w_load_valid captures the next word. Words 1..25 are weights w1..w25, matching the in_data index. Word 26 is the bias. Capturing word 26 → READY. No timeout.
- READY: w_ready=1. A w_load_valid in READY discards the kernel and starts a new load (→ LOAD, capture as w1, w_ready drops next cycle).
- in_valid is accepted only in READY and only when w_load_valid=0. Otherwise the window is dropped: no output, and the position counter does not advance.
- Arithmetic:
  - product = {1'b0,pixel} × sign-extended weight: 17-bit signed.
  - The 25 products are summed and bias is added, sign-extended, in a 24-bit signed accumulator. No overflow is possible.
  - The result is shifted right by SHIFT, arithmetic (floor).
  - ReLU: negative → 0.
  - Saturate: >255 → 255.
- Pipeline, one window per cycle, no back-pressure:
  - S1 registers the 25 products and a bias snapshot.
  - S2 registers five row partial sums.
  - S3 registers the total plus bias.
  - S4 registers requantized out_data and out_valid.
- Reloading weights never corrupts in-flight windows; each result uses the weights and bias sampled at S1.
- Position counter (col 0..OUT_W-1, row 0..OUT_H-1) advances on each accepted window and travels down the pipeline with it.
- out_last accompanies the result whose position is (OUT_H-1, OUT_W-1). The counter then wraps to (0,0) for the next image.

## Timing
- Reset values: w_ready=0, out_data=0, out_valid=0, out_last=0, conv_done_intr=0, FSM=EMPTY, counters=0, all pipeline valids=0.
- Reset mid-operation: in-flight results are lost, weights are invalidated, and no done pulse is generated.
- Latency: a window accepted at edge N produces out_valid at edge N+4. Throughput is 1 window/cycle.
- w_ready rises the cycle after word 26 is captured. A window presented in that same cycle is dropped.
- conv_done_intr is high exactly one cycle, at edge N+5 for a final window accepted at edge N. out_valid and out_last are low that cycle unless a new window follows back-to-back.
- Gaps in in_valid are allowed anywhere and create matching gaps in out_valid.

## Test plan
- Load w=+1 ×25, bias=0; send one window of all 10 → out_data=15 (250>>4) exactly 4 cycles after in_valid; out_last=0.
- Window all 255 with w=+127 ×25, bias=0 → 255 (saturated). Same window with w=−1 ×25 → 0 (ReLU).
- Pixels all 0, bias=+100 → 6. Bias=−100 → 0. Single nonzero weight w13=+16 with pixel13=200 → 200.
- Stream 576 back-to-back windows with the kernel loaded → 576 out_valid; out_last only on the 576th; conv_done_intr pulses one cycle later. The next window restarts at (0,0).
- Assert in_valid before the load completes and during a reload → those windows produce no output and the counter does not advance. In-flight windows complete with the old kernel.
- Assert i_rst asynchronously mid-stream → all outputs go to 0 immediately, w_ready=0. After reload and 576 windows, out_last lands correctly.

Source files
------------

// File: rtl/conv5x5_pe.sv
// Quantized 5x5 convolution PE: run-time kernel/bias load, 4-stage MAC pipeline,
// ReLU/saturating requantization to uint8, and feature-map position tracking.
module conv5x5_pe #(
    parameter int unsigned OUT_W = 24,
    parameter int unsigned OUT_H = 24,
    parameter int unsigned SHIFT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  in_data1,  input logic [7:0] in_data2,  input logic [7:0] in_data3,
    input  logic [7:0]  in_data4,  input logic [7:0] in_data5,  input logic [7:0] in_data6,
    input  logic [7:0]  in_data7,  input logic [7:0] in_data8,  input logic [7:0] in_data9,
    input  logic [7:0]  in_data10, input logic [7:0] in_data11, input logic [7:0] in_data12,
    input  logic [7:0]  in_data13, input logic [7:0] in_data14, input logic [7:0] in_data15,
    input  logic [7:0]  in_data16, input logic [7:0] in_data17, input logic [7:0] in_data18,
    input  logic [7:0]  in_data19, input logic [7:0] in_data20, input logic [7:0] in_data21,
    input  logic [7:0]  in_data22, input logic [7:0] in_data23, input logic [7:0] in_data24,
    input  logic [7:0]  in_data25,
    input  logic        in_valid,
    input  logic        w_load_valid,
    input  logic [15:0] w_load_data,
    output logic        w_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        conv_done_intr
);
    localparam int unsigned NTAP = 25;
    localparam int unsigned NROW = 5;
    localparam int unsigned PW   = 17;
    localparam int unsigned AW   = 24;
    localparam int unsigned LW   = 5;
    localparam int unsigned CW   = $clog2(OUT_W + 1);
    localparam int unsigned RW   = $clog2(OUT_H + 1);
    localparam logic signed [AW-1:0] SAT_MAX = AW'(255);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          cnt_q;
    logic signed [7:0]      w_q [NTAP];
    logic signed [15:0]     bias_q;
    logic [7:0]             pix [NTAP];
    logic                   accept_c;
    logic [CW-1:0]          col_q;
    logic [RW-1:0]          row_q;
    logic                   last_c;

    logic signed [PW-1:0]   prod_c [NTAP];
    logic signed [PW-1:0]   p1_q [NTAP];
    logic signed [15:0]     b1_q;
    logic                   v1_q, l1_q;
    logic signed [AW-1:0]   rs_c [NROW];
    logic signed [AW-1:0]   rs_q [NROW];
    logic signed [15:0]     b2_q;
    logic                   v2_q, l2_q;
    logic signed [AW-1:0]   tot_c, tot_q;
    logic                   v3_q, l3_q;
    logic signed [AW-1:0]   sh_c;

    assign pix = '{in_data1,  in_data2,  in_data3,  in_data4,  in_data5,
                   in_data6,  in_data7,  in_data8,  in_data9,  in_data10,
                   in_data11, in_data12, in_data13, in_data14, in_data15,
                   in_data16, in_data17, in_data18, in_data19, in_data20,
                   in_data21, in_data22, in_data23, in_data24, in_data25};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (w_load_valid) state_d = LOAD;
            LOAD:    if (w_load_valid && cnt_q == LW'(NTAP)) state_d = READY;
            READY:   if (w_load_valid) state_d = LOAD;
            default: state_d = EMPTY;
        endcase
    end

    // Kernel/bias capture; any load that does not continue an ongoing one restarts at w1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            bias_q  <= '0;
            w_ready <= 1'b0;
            for (int i = 0; i < NTAP; i++) w_q[i] <= '0;
        end else begin
            w_ready <= (state_d == READY);
            if (w_load_valid) begin
                if (state_q == LOAD && cnt_q == LW'(NTAP)) begin
                    bias_q <= w_load_data;
                end else if (state_q == LOAD) begin
                    w_q[cnt_q] <= w_load_data[7:0];
                    cnt_q      <= cnt_q + LW'(1);
                end else begin
                    w_q[0] <= w_load_data[7:0];
                    cnt_q  <= LW'(1);
                end
            end
        end
    end

    assign accept_c = (state_q == READY) && in_valid && !w_load_valid;
    assign last_c   = (col_q == CW'(OUT_W - 1)) && (row_q == RW'(OUT_H - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept_c) begin
            if (col_q == CW'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(OUT_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NTAP; i++)
            prod_c[i] = PW'($signed({1'b0, pix[i]})) * PW'(w_q[i]);
        for (int r = 0; r < NROW; r++) begin
            rs_c[r] = '0;
            for (int c = 0; c < NROW; c++) rs_c[r] = rs_c[r] + AW'(p1_q[r*NROW + c]);
        end
        tot_c = AW'(b2_q);
        for (int r = 0; r < NROW; r++) tot_c = tot_c + rs_q[r];
        sh_c = tot_q >>> SHIFT;
    end

    // S1..S4: products, row sums, total+bias, requantized output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NTAP; i++) p1_q[i] <= '0;
            for (int r = 0; r < NROW; r++) rs_q[r] <= '0;
            b1_q           <= '0;
            b2_q           <= '0;
            tot_q          <= '0;
            {v1_q, v2_q, v3_q} <= '0;
            {l1_q, l2_q, l3_q} <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            conv_done_intr <= 1'b0;
        end else begin
            for (int i = 0; i < NTAP; i++) p1_q[i] <= prod_c[i];
            b1_q  <= bias_q;
            v1_q  <= accept_c;
            l1_q  <= accept_c && last_c;
            rs_q  <= rs_c;
            b2_q  <= b1_q;
            v2_q  <= v1_q;
            l2_q  <= l1_q;
            tot_q <= tot_c;
            v3_q  <= v2_q;
            l3_q  <= l2_q;
            if (sh_c < 0)            out_data <= 8'd0;
            else if (sh_c > SAT_MAX) out_data <= 8'd255;
            else                     out_data <= sh_c[7:0];
            out_valid      <= v3_q;
            out_last       <= l3_q;
            conv_done_intr <= out_valid && out_last;
        end
    end
endmodule

// File: tb/tb_conv5x5_pe.sv
// Scoreboard bench for conv5x5_pe: directed windows with hand-computed results,
// full-image streaming, dropped windows, reload and async reset.
module tb_conv5x5_pe;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  px [25];
    logic        in_valid, w_load_valid;
    logic [15:0] w_load_data;
    logic        w_ready, out_valid, out_last, conv_done_intr;
    logic [7:0]  out_data;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         cyc;
    } exp_t;

    exp_t        sbq [$];
    int          checks = 0, failures = 0;
    int          cyc = 0;
    int          pos_cnt = 0;
    logic        prev_last = 1'b0;
    logic signed [7:0]  kw [25];
    logic signed [15:0] kb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv5x5_pe #(.OUT_W(24), .OUT_H(24), .SHIFT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .in_data1(px[0]),   .in_data2(px[1]),   .in_data3(px[2]),   .in_data4(px[3]),
        .in_data5(px[4]),   .in_data6(px[5]),   .in_data7(px[6]),   .in_data8(px[7]),
        .in_data9(px[8]),   .in_data10(px[9]),  .in_data11(px[10]), .in_data12(px[11]),
        .in_data13(px[12]), .in_data14(px[13]), .in_data15(px[14]), .in_data16(px[15]),
        .in_data17(px[16]), .in_data18(px[17]), .in_data19(px[18]), .in_data20(px[19]),
        .in_data21(px[20]), .in_data22(px[21]), .in_data23(px[22]), .in_data24(px[23]),
        .in_data25(px[24]),
        .in_valid(in_valid), .w_load_valid(w_load_valid), .w_load_data(w_load_data),
        .w_ready(w_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .conv_done_intr(conv_done_intr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid and checks the done pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
                    chk("out_last", int'(out_last), int'(e.last));
                    chk("latency", cyc, e.cyc);
                end
            end
            if (prev_last || conv_done_intr)
                chk("conv_done_intr", int'(conv_done_intr), int'(prev_last));
            prev_last = out_valid && out_last;
        end
    end

    task automatic set_px(input logic [7:0] v);
        for (int i = 0; i < 25; i++) px[i] = v;
    endtask

    task automatic set_kw(input logic signed [7:0] v);
        for (int i = 0; i < 25; i++) kw[i] = v;
    endtask

    task automatic load(input bit noisy);
        for (int i = 0; i < 26; i++) begin
            w_load_valid = 1'b1;
            w_load_data  = (i < 25) ? {8'hA5, kw[i]} : kb;
            in_valid     = noisy;
            @(posedge clk); #1;
            if (i == 0) chk("w_ready_low_in_load", int'(w_ready), 0);
        end
        w_load_valid = 1'b0;
        in_valid     = 1'b0;
        chk("w_ready_after_load", int'(w_ready), 1);
    endtask

    task automatic send(input logic [7:0] exp, input bit acc);
        exp_t e;
        in_valid = 1'b1;
        if (acc) begin
            e.d    = exp;
            e.last = (pos_cnt == 575);
            e.cyc  = cyc + 4;
            sbq.push_back(e);
            pos_cnt = (pos_cnt + 1) % 576;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) begin @(posedge clk); #1; end
        chk("drain_queue_empty", sbq.size(), 0);
        idle(2);
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done", int'(conv_done_intr), 0);
        chk("rst_w_ready", int'(w_ready), 0);
        sbq.delete();
        pos_cnt = 0;
        in_valid = 1'b0;
        w_load_valid = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic stream(input int n);
        int e;
        for (int k = 0; k < n; k++) begin
            set_px(8'(k % 256));
            e = (25 * (k % 256)) >> 4;
            if (e > 255) e = 255;
            send(8'(e), 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        w_load_valid = 1'b0;
        w_load_data = '0;
        set_px(8'd0);
        set_kw(8'sd0);
        kb = '0;
        #1;
        async_reset();

        // Nothing loaded yet: window must be dropped.
        set_px(8'd10);
        send(8'd0, 1'b0);

        set_kw(8'sd1); kb = 16'sd0;
        load(1'b1);
        set_px(8'd10);   send(8'd15, 1'b1);   idle(6);

        set_kw(8'sd127); load(1'b0);
        set_px(8'd255);  send(8'd255, 1'b1);
        set_kw(-8'sd1);  load(1'b0);
        set_px(8'd255);  send(8'd0, 1'b1);

        kb = 16'sd100;   load(1'b0);
        set_px(8'd0);    send(8'd6, 1'b1);
        kb = -16'sd100;  load(1'b0);
        set_px(8'd0);    send(8'd0, 1'b1);

        set_kw(8'sd0); kw[12] = 8'sd16; kb = 16'sd0; load(1'b0);
        set_px(8'd255); px[12] = 8'd200; send(8'd200, 1'b1);

        set_kw(8'sd0); kw[0] = 8'sd16; kw[24] = 8'sd32; load(1'b0);
        set_px(8'd0); px[0] = 8'd100; px[24] = 8'd5; send(8'd110, 1'b1);

        for (int i = 0; i < 25; i++) begin
            kw[i] = 8'(i - 12);
            px[i] = 8'((i + 1) * 10);
        end
        kb = -16'sd12000; load(1'b0);
        send(8'd62, 1'b1);
        drain();

        // Reload right behind in-flight windows: they must finish with the old kernel.
        set_kw(8'sd1); kb = 16'sd0; load(1'b0);
        set_px(8'd10); send(8'd15, 1'b1);
        set_px(8'd20); send(8'd31, 1'b1);
        set_px(8'd30); send(8'd46, 1'b1);
        set_kw(-8'sd1); kb = 16'sd1000;
        load(1'b1);
        set_px(8'd10); send(8'd46, 1'b1);
        drain();

        // Full image from (0,0).
        async_reset();
        set_kw(8'sd1); kb = 16'sd0; load(1'b0);
        stream(576);
        drain();
        set_px(8'd16); send(8'd25, 1'b1);
        drain();

        // Async reset mid-stream, then a clean image.
        async_reset();
        load(1'b0);
        stream(300);
        async_reset();
        chk("queue_flushed", sbq.size(), 0);
        load(1'b0);
        stream(576);
        set_px(8'd32); send(8'd50, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
